// File: rtl/qr_unmask_gen_if.sv
// Handshake and grid bus between the downsampler, the unmask stage and the codeword reader.
// Slave side is the unmask stage; master side drives start_in/qr_in and consumes results.
interface qr_unmask_gen_if #(
  parameter int MOD_SIZE = 21
);
  logic                           start_in;
  logic [MOD_SIZE*MOD_SIZE-1:0]   qr_in;
  logic [MOD_SIZE*MOD_SIZE-1:0]   qr_out;
  logic [2:0]                     mask_id_out;
  logic [1:0]                     ecc_level_out;
  logic                           format_ok_out;
  logic                           busy_out;
  logic                           done_out;

  modport master (
    output start_in, qr_in,
    input  qr_out, mask_id_out, ecc_level_out, format_ok_out, busy_out, done_out
  );

  modport slave (
    input  start_in, qr_in,
    output qr_out, mask_id_out, ecc_level_out, format_ok_out, busy_out, done_out
  );
endinterface

// File: rtl/qr_unmask_gen.sv
// QR unmask stage: validates both format copies (BCH), XORs the chosen mask over data modules, LANES per cycle.
// Latency 2+N*N/LANES cycles from start_in to done_out; no backpressure, start_in is ignored unless IDLE.
module qr_unmask_gen #(
  parameter int MOD_SIZE = 21,
  parameter int LANES    = 1
) (
  input  logic           clk_in,
  input  logic           rst_in,
  qr_unmask_gen_if.slave bus
);
  localparam int          NN       = MOD_SIZE * MOD_SIZE;
  localparam int          IW       = $clog2(NN);
  localparam logic [5:0]  LAST_ROW = 6'(MOD_SIZE - 1);
  localparam logic [5:0]  LAST_COL = 6'(MOD_SIZE - LANES);
  localparam logic [5:0]  STEP     = 6'(LANES);
  localparam logic [5:0]  FND_LO   = 6'(MOD_SIZE - 8);
  localparam logic [5:0]  ALN_LO   = 6'(MOD_SIZE - 9);
  localparam logic [5:0]  ALN_HI   = 6'(MOD_SIZE - 5);
  localparam bit          HAS_ALN  = (MOD_SIZE >= 25);
  localparam logic [14:0] FMT_XOR  = 15'b101010000010010;
  localparam logic [10:0] BCH_GEN  = 11'b10100110111;

  if (MOD_SIZE < 21 || MOD_SIZE > 41 || (MOD_SIZE - 17) % 4 != 0) begin : g_bad_mod_size
    $error("qr_unmask_gen: MOD_SIZE must be 4k+17 within 21..41");
  end
  if (LANES < 1 || MOD_SIZE % LANES != 0) begin : g_bad_lanes
    $error("qr_unmask_gen: LANES must divide MOD_SIZE");
  end

  typedef enum logic [2:0] {S_IDLE, S_LATCH, S_DECODE, S_SCAN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [NN-1:0]   grid_q, qr_q;
  logic [14:0]     raw_a_q, raw_b_q;
  logic [14:0]     copy_a, copy_b, fmt_a, fmt_b, fmt_sel;
  logic            ok_a, ok_b;
  logic [5:0]      row_q, col_q;
  logic [2:0]      mask_q;
  logic [1:0]      ecc_q;
  logic            fmt_ok_q;
  logic            busy, done, scan_last;
  logic [IW-1:0]   lane_idx [LANES];
  logic            lane_bit [LANES];

  function automatic logic [IW-1:0] at(input int r, input int c);
    return IW'(r * MOD_SIZE + c);
  endfunction

  function automatic logic bch_ok(input logic [14:0] w);
    logic [14:0] v;
    v = w;
    for (int i = 14; i >= 10; i--)
      if (v[4'(i)]) v = v ^ (15'(BCH_GEN) << (i - 10));
    return v[9:0] == 10'd0;
  endfunction

  function automatic logic mask_hit(input logic [2:0] id, input logic [5:0] r, input logic [5:0] c);
    logic [10:0] rr, cc, s, p;
    rr = {5'd0, r};
    cc = {5'd0, c};
    s  = rr + cc;
    p  = rr * cc;
    case (id)
      3'd0:    return (s % 11'd2) == 11'd0;
      3'd1:    return (rr % 11'd2) == 11'd0;
      3'd2:    return (cc % 11'd3) == 11'd0;
      3'd3:    return (s % 11'd3) == 11'd0;
      3'd4:    return (((rr / 11'd2) + (cc / 11'd3)) % 11'd2) == 11'd0;
      3'd5:    return ((p % 11'd2) + (p % 11'd3)) == 11'd0;
      3'd6:    return (((p % 11'd2) + (p % 11'd3)) % 11'd2) == 11'd0;
      default: return (((s % 11'd2) + (p % 11'd3)) % 11'd2) == 11'd0;
    endcase
  endfunction

  function automatic logic is_func(input logic [5:0] r, input logic [5:0] c);
    logic fnd, tmg, aln;
    fnd = (r < 6'd9 && c < 6'd9) || (r < 6'd9 && c >= FND_LO) || (r >= FND_LO && c < 6'd9);
    tmg = (r == 6'd6) || (c == 6'd6);
    aln = HAS_ALN && r >= ALN_LO && r <= ALN_HI && c >= ALN_LO && c <= ALN_HI;
    return fnd || tmg || aln;
  endfunction

  // Raw format copies straight off the input grid, captured in LATCH.
  always_comb begin
    copy_a = '0;
    copy_b = '0;
    for (int i = 0; i < 6; i++) copy_a[4'(14 - i)] = bus.qr_in[at(8, i)];
    copy_a[8] = bus.qr_in[at(8, 7)];
    copy_a[7] = bus.qr_in[at(8, 8)];
    copy_a[6] = bus.qr_in[at(7, 8)];
    for (int i = 0; i < 6; i++) copy_a[4'(5 - i)] = bus.qr_in[at(5 - i, 8)];
    for (int i = 0; i < 7; i++) copy_b[4'(14 - i)] = bus.qr_in[at(MOD_SIZE - 1 - i, 8)];
    for (int j = 0; j < 8; j++) copy_b[4'(7 - j)] = bus.qr_in[at(8, MOD_SIZE - 8 + j)];
  end

  always_comb begin
    fmt_a   = raw_a_q ^ FMT_XOR;
    fmt_b   = raw_b_q ^ FMT_XOR;
    ok_a    = bch_ok(fmt_a);
    ok_b    = bch_ok(fmt_b);
    fmt_sel = (!ok_a && ok_b) ? fmt_b : fmt_a;
  end

  always_comb begin
    lane_idx = '{default: '0};
    lane_bit = '{default: 1'b0};
    for (int l = 0; l < LANES; l++) begin
      lane_idx[l] = IW'(int'(row_q) * MOD_SIZE + int'(col_q) + l);
      lane_bit[l] = grid_q[lane_idx[l]] ^
                    (mask_hit(mask_q, row_q, col_q + 6'(l)) & ~is_func(row_q, col_q + 6'(l)));
    end
  end

  assign scan_last = (row_q == LAST_ROW) && (col_q == LAST_COL);

  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE:   if (bus.start_in) state_d = S_LATCH;
      S_LATCH:  begin busy = 1'b1; state_d = S_DECODE; end
      S_DECODE: begin busy = 1'b1; state_d = S_SCAN; end
      S_SCAN:   begin busy = 1'b1; if (scan_last) state_d = S_DONE; end
      S_DONE:   begin done = 1'b1; state_d = S_IDLE; end
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      grid_q   <= '0;
      qr_q     <= '0;
      raw_a_q  <= '0;
      raw_b_q  <= '0;
      row_q    <= '0;
      col_q    <= '0;
      mask_q   <= '0;
      ecc_q    <= '0;
      fmt_ok_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (bus.start_in) qr_q <= '0;
        S_LATCH: begin
          grid_q  <= bus.qr_in;
          raw_a_q <= copy_a;
          raw_b_q <= copy_b;
          row_q   <= '0;
          col_q   <= '0;
        end
        S_DECODE: begin
          mask_q   <= fmt_sel[12:10];
          ecc_q    <= fmt_sel[14:13];
          fmt_ok_q <= ok_a | ok_b;
        end
        S_SCAN: begin
          for (int l = 0; l < LANES; l++) qr_q[lane_idx[l]] <= lane_bit[l];
          if (col_q == LAST_COL) begin
            col_q <= '0;
            row_q <= row_q + 6'd1;
          end else begin
            col_q <= col_q + STEP;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.qr_out        = qr_q;
  assign bus.mask_id_out   = mask_q;
  assign bus.ecc_level_out = ecc_q;
  assign bus.format_ok_out = fmt_ok_q;
  assign bus.busy_out      = busy;
  assign bus.done_out      = done;
endmodule

// File: tb/tb_qr_unmask_gen.sv
// Bench for qr_unmask_gen: N=21/LANES=1 and N=25/LANES=5 instances share stimulus through a select.
module tb_qr_unmask_gen;
  localparam int          MAXG    = 625;
  localparam logic [14:0] FMT_XOR = 15'b101010000010010;
  localparam logic [10:0] GEN     = 11'b10100110111;

  typedef struct {
    logic [14:0] a;
    logic [14:0] b;
    bit          rnd;
    bit          n25;
    logic [2:0]  exp_mask;
    logic [1:0]  exp_ecc;
    bit          exp_ok;
  } vec_t;

  typedef struct {
    logic [MAXG-1:0] grid;
    logic [2:0]      mask;
    logic [1:0]      ecc;
    bit              ok;
    int              lat;
  } exp_t;

  logic            clk_in = 1'b0;
  logic            rst_in;
  logic            start;
  logic            sel25;
  logic [MAXG-1:0] grid_drv;
  logic [MAXG-1:0] o_qr;
  logic [2:0]      o_mask;
  logic [1:0]      o_ecc;
  logic            o_ok, o_busy, o_done;
  int              n_tests = 0;
  int              n_fail  = 0;
  vec_t            tbl[$];
  exp_t            sb[$];

  always #5 clk_in = ~clk_in;

  qr_unmask_gen_if #(.MOD_SIZE(21)) if21 ();
  qr_unmask_gen_if #(.MOD_SIZE(25)) if25 ();

  assign if21.start_in = start & ~sel25;
  assign if21.qr_in    = grid_drv[440:0];
  assign if25.start_in = start & sel25;
  assign if25.qr_in    = grid_drv;

  qr_unmask_gen #(.MOD_SIZE(21), .LANES(1)) u21 (.clk_in(clk_in), .rst_in(rst_in), .bus(if21));
  qr_unmask_gen #(.MOD_SIZE(25), .LANES(5)) u25 (.clk_in(clk_in), .rst_in(rst_in), .bus(if25));

  always_comb begin
    o_qr = '0; o_mask = '0; o_ecc = '0; o_ok = 1'b0; o_busy = 1'b0; o_done = 1'b0;
    if (sel25) begin
      o_qr = if25.qr_out; o_mask = if25.mask_id_out; o_ecc = if25.ecc_level_out;
      o_ok = if25.format_ok_out; o_busy = if25.busy_out; o_done = if25.done_out;
    end else begin
      o_qr = {184'd0, if21.qr_out}; o_mask = if21.mask_id_out; o_ecc = if21.ecc_level_out;
      o_ok = if21.format_ok_out; o_busy = if21.busy_out; o_done = if21.done_out;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_grid(input string nm, input logic [MAXG-1:0] act, input logic [MAXG-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Codewords of the format BCH code are exactly the carry-less multiples of the generator.
  function automatic logic [14:0] clmul(input int m);
    logic [14:0] p;
    p = '0;
    for (int k = 0; k < 5; k++) if (m[k]) p = p ^ (15'(GEN) << k);
    return p;
  endfunction

  function automatic logic [14:0] fmt_word(input logic [4:0] d);
    logic [14:0] w;
    w = '0;
    for (int m = 0; m < 32; m++) if (clmul(m) >> 10 == 15'(d)) w = clmul(m);
    return w ^ FMT_XOR;
  endfunction

  function automatic bit tb_mask(input int id, input int r, input int c);
    case (id)
      0: return ((r + c) % 2) == 0;
      1: return (r % 2) == 0;
      2: return (c % 3) == 0;
      3: return ((r + c) % 3) == 0;
      4: return ((r / 2 + c / 3) % 2) == 0;
      5: return ((r * c) % 2 + (r * c) % 3) == 0;
      6: return (((r * c) % 2 + (r * c) % 3) % 2) == 0;
      default: return (((r + c) % 2 + (r * c) % 3) % 2) == 0;
    endcase
  endfunction

  function automatic bit tb_func(input int n, input int r, input int c);
    bit fnd, aln;
    fnd = (r < 9 && c < 9) || (r < 9 && c >= n - 8) || (r >= n - 8 && c < 9);
    aln = (n >= 25) && r >= n - 9 && r <= n - 5 && c >= n - 9 && c <= n - 5;
    return fnd || aln || r == 6 || c == 6;
  endfunction

  function automatic logic [MAXG-1:0] build_grid(input int n, input logic [14:0] a,
                                                  input logic [14:0] b, input bit rnd);
    logic [MAXG-1:0] g;
    int ar[15] = '{8, 8, 8, 8, 8, 8, 8, 8, 7, 5, 4, 3, 2, 1, 0};
    int ac[15] = '{0, 1, 2, 3, 4, 5, 7, 8, 8, 8, 8, 8, 8, 8, 8};
    g = '0;
    if (rnd) for (int i = 0; i < n * n; i++) g[i] = 1'($urandom());
    for (int i = 0; i < 15; i++) g[ar[i] * n + ac[i]] = a[14 - i];
    for (int i = 0; i < 7; i++) g[(n - 1 - i) * n + 8] = b[14 - i];
    for (int j = 0; j < 8; j++) g[8 * n + n - 8 + j] = b[7 - j];
    return g;
  endfunction

  function automatic logic [MAXG-1:0] model_grid(input int n, input logic [MAXG-1:0] g, input int id);
    logic [MAXG-1:0] o;
    o = g;
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++)
        if (tb_mask(id, r, c) && !tb_func(n, r, c)) o[r * n + c] = ~g[r * n + c];
    return o;
  endfunction

  task automatic add(input logic [14:0] a, input logic [14:0] b, input bit rnd, input bit n25,
                     input logic [2:0] m, input logic [1:0] e, input bit ok);
    vec_t v;
    v.a = a; v.b = b; v.rnd = rnd; v.n25 = n25; v.exp_mask = m; v.exp_ecc = e; v.exp_ok = ok;
    tbl.push_back(v);
  endtask

  task automatic kick(input int k, input bit push);
    exp_t e;
    int   n;
    n = tbl[k].n25 ? 25 : 21;
    @(negedge clk_in);
    sel25    = tbl[k].n25;
    grid_drv = build_grid(n, tbl[k].a, tbl[k].b, tbl[k].rnd);
    e.grid   = model_grid(n, grid_drv, int'(tbl[k].exp_mask));
    e.mask   = tbl[k].exp_mask;
    e.ecc    = tbl[k].exp_ecc;
    e.ok     = tbl[k].exp_ok;
    e.lat    = 2 + n * n / (tbl[k].n25 ? 5 : 1);
    if (push) sb.push_back(e);
    start = 1'b1;
    @(posedge clk_in); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int elapsed);
    exp_t e;
    int   cyc;
    bit   seen, busy_ok;
    cyc = elapsed; seen = 1'b0; busy_ok = 1'b1;
    while (!seen && cyc < 3000) begin
      @(posedge clk_in); #1;
      cyc++;
      if (o_done) seen = 1'b1;
      else if (!o_busy) busy_ok = 1'b0;
    end
    chk("done_seen", 64'(seen), 64'd1);
    if (sb.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL scoreboard: got 0 queued entries expected 1");
    end else begin
      e = sb.pop_front();
      chk("latency", 64'(cyc), 64'(e.lat));
      chk("busy_during_run", 64'(busy_ok), 64'd1);
      chk("mask_id", 64'(o_mask), 64'(e.mask));
      chk("ecc_level", 64'(o_ecc), 64'(e.ecc));
      chk("format_ok", 64'(o_ok), 64'(e.ok));
      chk_grid("qr_out", o_qr, e.grid);
    end
    start = 1'b1;  // a request in the DONE cycle must not launch a run
    @(posedge clk_in); #1;
    start = 1'b0;
    chk("start_in_done_ignored", 64'(o_busy), 64'd0);
    chk("done_one_cycle", 64'(o_done), 64'd0);
  endtask

  task automatic run(input int k);
    kick(k, 1'b1);
    wait_done(0);
  endtask

  task automatic count_dones(input int cycles, output int cnt);
    cnt = 0;
    repeat (cycles) begin
      @(posedge clk_in); #1;
      if (o_done) cnt++;
    end
  endtask

  initial begin
    int  cnt;
    bit  aln_ok;
    logic [4:0] ds[6] = '{5'd1, 5'd18, 5'd28, 5'd13, 5'd6, 5'd23};

    add(15'b111011111000100, 15'b111011111000100, 0, 0, 3'b000, 2'b01, 1);  // 0: L mask 0
    add(15'b111100010001101, 15'b111100010011101, 0, 0, 3'b011, 2'b01, 1);  // 1: A damaged, B good
    add(15'b000000000000001, 15'b000000000000001, 0, 0, 3'b101, 2'b10, 0);  // 2: both bad
    add(15'b111011111000100, 15'b111011111000100, 0, 1, 3'b000, 2'b01, 1);  // 3: N=25 mask 0
    for (int i = 0; i < 6; i++)
      add(fmt_word(ds[i]), fmt_word(ds[i]), 1, 0, ds[i][2:0], ds[i][4:3], 1);
    add(fmt_word(5'd13), fmt_word(5'd18), 1, 0, 3'b101, 2'b01, 1);          // A and B disagree: A wins
    add(fmt_word(5'd7) ^ 15'b000010000100001, fmt_word(5'd26), 1, 0, 3'b010, 2'b11, 1);
    add(fmt_word(5'd30), fmt_word(5'd30), 1, 1, 3'b110, 2'b11, 1);

    rst_in = 1'b1; start = 1'b0; sel25 = 1'b0; grid_drv = '0;
    repeat (3) @(posedge clk_in);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel25 = s[0];
      #1;
      chk("rst_busy", 64'(o_busy), 64'd0);
      chk("rst_done", 64'(o_done), 64'd0);
      chk("rst_mask", 64'(o_mask), 64'd0);
      chk("rst_fmt_ok", 64'(o_ok), 64'd0);
      chk_grid("rst_qr_out", o_qr, '0);
    end
    rst_in = 1'b0;

    for (int k = 0; k < tbl.size(); k++) run(k);

    run(0);
    chk("m0_9_9", 64'(o_qr[9*21+9]), 64'd1);
    chk("m0_9_10", 64'(o_qr[9*21+10]), 64'd0);
    chk("m0_timing_6_10", 64'(o_qr[6*21+10]), 64'd0);
    chk("m0_finder_0_0", 64'(o_qr[0]), 64'd0);

    run(1);
    chk("m3_10_11", 64'(o_qr[10*21+11]), 64'd1);
    chk("m3_9_9", 64'(o_qr[9*21+9]), 64'd1);

    run(3);
    aln_ok = 1'b1;
    for (int r = 16; r <= 20; r++)
      for (int c = 16; c <= 20; c++)
        if (o_qr[r*25+c] !== 1'b0) aln_ok = 1'b0;
    chk("n25_align_untouched", 64'(aln_ok), 64'd1);
    chk("n25_15_15", 64'(o_qr[15*25+15]), 64'd1);

    // Reset in the middle of SCAN.
    kick(0, 1'b0);
    repeat (101) @(posedge clk_in);
    #1 rst_in = 1'b1;
    @(posedge clk_in); #1;
    chk("midrst_busy", 64'(o_busy), 64'd0);
    chk("midrst_done", 64'(o_done), 64'd0);
    chk("midrst_fmt_ok", 64'(o_ok), 64'd0);
    chk("midrst_ecc", 64'(o_ecc), 64'd0);
    chk_grid("midrst_qr_out", o_qr, '0);
    rst_in = 1'b0;
    count_dones(600, cnt);
    chk("midrst_no_done", 64'(cnt), 64'd0);
    run(0);

    // Input grid changes after LATCH and a stray start in SCAN; result follows the latched grid.
    kick(4, 1'b1);
    @(posedge clk_in); #1;
    for (int i = 0; i < MAXG; i++) grid_drv[i] = 1'($urandom());
    repeat (11) @(posedge clk_in);
    #1 start = 1'b1;
    @(posedge clk_in); #1;
    start = 1'b0;
    wait_done(13);
    count_dones(500, cnt);
    chk("single_done", 64'(cnt), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
